// File: rtl/lap_timer.sv
// rtl/lap_timer.sv - race lap counter with current/last/best lap and total race timers
module lap_timer #(
   parameter int TICK_DIV = 650000,
   parameter int LAPS     = 3
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        race_start,
   input  logic        lap_finished,
   input  logic        checkpoints_passed,
   output logic [3:0]  lap_count,
   output logic [15:0] lap_time,
   output logic [15:0] last_lap,
   output logic [15:0] best_lap,
   output logic [19:0] race_time,
   output logic        lap_done,
   output logic        race_running,
   output logic        race_finished
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RUNNING  = 2'd1;
   localparam logic [1:0] S_FINISHED = 2'd2;

   logic [1:0]    r_state;
   logic [PW-1:0] r_presc;
   logic          r_lf_d;
   logic [3:0]    r_lap_count;
   logic [15:0]   r_lap_time;
   logic [15:0]   r_last_lap;
   logic [15:0]   r_best_lap;
   logic [19:0]   r_race_time;
   logic          r_lap_done;
   logic          r_race_running;
   logic          r_race_finished;

   logic          w_tick;
   logic          w_valid_lap;
   logic [15:0]   w_best_next;
   logic [3:0]    w_count_next;

   assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
   // Only the first cycle inside the finish zone can count, and only with all checkpoints collected
   assign w_valid_lap  = lap_finished & ~r_lf_d & checkpoints_passed;
   assign w_best_next  = (r_lap_time < r_best_lap) ? r_lap_time : r_best_lap;
   assign w_count_next = r_lap_count + 4'd1;

   // Race state, prescaler and all timers; race_start overrides everything, including a lap in the same cycle
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_presc         <= '0;
         r_lf_d          <= 1'b0;
         r_lap_count     <= '0;
         r_lap_time      <= '0;
         r_last_lap      <= '0;
         r_best_lap      <= 16'hFFFF;
         r_race_time     <= '0;
         r_lap_done      <= 1'b0;
         r_race_running  <= 1'b0;
         r_race_finished <= 1'b0;
      end else begin
         r_lf_d     <= lap_finished;
         r_lap_done <= 1'b0;
         if (race_start) begin
            r_state         <= S_RUNNING;
            r_race_running  <= 1'b1;
            r_race_finished <= 1'b0;
            r_presc         <= '0;
            r_lap_count     <= '0;
            r_lap_time      <= '0;
            r_last_lap      <= '0;
            r_best_lap      <= 16'hFFFF;
            r_race_time     <= '0;
         end else if (r_state == S_RUNNING) begin
            // The race clock keeps ticking across a lap boundary; the lap clock restarts from zero
            if (w_tick && (r_race_time != '1))
               r_race_time <= r_race_time + 20'd1;
            if (w_valid_lap) begin
               r_last_lap  <= r_lap_time;
               r_best_lap  <= w_best_next;
               r_lap_count <= w_count_next;
               r_lap_time  <= '0;
               r_presc     <= '0;
               r_lap_done  <= 1'b1;
               if (w_count_next == 4'(LAPS)) begin
                  r_state         <= S_FINISHED;
                  r_race_running  <= 1'b0;
                  r_race_finished <= 1'b1;
               end
            end else begin
               r_presc <= w_tick ? '0 : r_presc + PW'(1);
               if (w_tick && (r_lap_time != '1))
                  r_lap_time <= r_lap_time + 16'd1;
            end
         end
      end
   end

   assign lap_count     = r_lap_count;
   assign lap_time      = r_lap_time;
   assign last_lap      = r_last_lap;
   assign best_lap      = r_best_lap;
   assign race_time     = r_race_time;
   assign lap_done      = r_lap_done;
   assign race_running  = r_race_running;
   assign race_finished = r_race_finished;

endmodule

// File: tb/tb_lap_timer.sv
// tb/tb_lap_timer.sv - directed self-checking bench for lap_timer
module tb_lap_timer;

   logic        pclk;
   logic        rst;
   logic        race_start;
   logic        lap_finished;
   logic        checkpoints_passed;
   logic [3:0]  lap_count;
   logic [15:0] lap_time;
   logic [15:0] last_lap;
   logic [15:0] best_lap;
   logic [19:0] race_time;
   logic        lap_done;
   logic        race_running;
   logic        race_finished;

   int checks;
   int errors;

   lap_timer #(.TICK_DIV(4), .LAPS(3)) dut (
      .pclk               (pclk),
      .rst                (rst),
      .race_start         (race_start),
      .lap_finished       (lap_finished),
      .checkpoints_passed (checkpoints_passed),
      .lap_count          (lap_count),
      .lap_time           (lap_time),
      .last_lap           (last_lap),
      .best_lap           (best_lap),
      .race_time          (race_time),
      .lap_done           (lap_done),
      .race_running       (race_running),
      .race_finished      (race_finished)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clk(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_count"},    32'(lap_count),     32'h0);
      chk({tag, "_lap"},      32'(lap_time),      32'h0);
      chk({tag, "_last"},     32'(last_lap),      32'h0);
      chk({tag, "_best"},     32'(best_lap),      32'hFFFF);
      chk({tag, "_race"},     32'(race_time),     32'h0);
      chk({tag, "_done"},     32'(lap_done),      32'h0);
      chk({tag, "_running"},  32'(race_running),  32'h0);
      chk({tag, "_finished"}, 32'(race_finished), 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      race_start = 1'b0;
      lap_finished = 1'b0;
      checkpoints_passed = 1'b0;

      // 1: reset, start, 40 clocks -> 10 ticks
      clk(2);
      chk_reset_values("rst");
      rst = 1'b0;
      clk(1);
      race_start = 1'b1;
      clk(1);
      race_start = 1'b0;
      chk("start_running", 32'(race_running), 32'h1);
      chk("start_lap", 32'(lap_time), 32'h0);
      clk(40);
      chk("s1_running", 32'(race_running), 32'h1);
      chk("s1_lap", 32'(lap_time), 32'd10);
      chk("s1_race", 32'(race_time), 32'd10);
      chk("s1_count", 32'(lap_count), 32'd0);
      chk("s1_best", 32'(best_lap), 32'hFFFF);

      // 2: rising edge without checkpoints is ignored
      lap_finished = 1'b1;
      checkpoints_passed = 1'b0;
      clk(1);
      chk("s2_done", 32'(lap_done), 32'h0);
      chk("s2_count", 32'(lap_count), 32'd0);
      lap_finished = 1'b0;
      clk(3);
      chk("s2_lap", 32'(lap_time), 32'd11);
      chk("s2_count2", 32'(lap_count), 32'd0);

      // 3: first valid lap at lap_time 25 (100 edges after start)
      clk(56);
      chk("s3_lap25", 32'(lap_time), 32'd25);
      lap_finished = 1'b1;
      checkpoints_passed = 1'b1;
      clk(1);
      chk("s3a_done", 32'(lap_done), 32'h1);
      chk("s3a_last", 32'(last_lap), 32'd25);
      chk("s3a_best", 32'(best_lap), 32'd25);
      chk("s3a_count", 32'(lap_count), 32'd1);
      chk("s3a_lap", 32'(lap_time), 32'd0);
      chk("s3a_race", 32'(race_time), 32'd25);
      // held high: no further pulses
      for (int i = 0; i < 9; i++) begin
         clk(1);
         chk("s3_hold_done", 32'(lap_done), 32'h0);
      end
      chk("s3_hold_count", 32'(lap_count), 32'd1);
      lap_finished = 1'b0;
      clk(63);
      chk("s3_lap18", 32'(lap_time), 32'd18);
      lap_finished = 1'b1;
      clk(1);
      chk("s3b_done", 32'(lap_done), 32'h1);
      chk("s3b_last", 32'(last_lap), 32'd18);
      chk("s3b_best", 32'(best_lap), 32'd18);
      chk("s3b_count", 32'(lap_count), 32'd2);
      chk("s3b_race", 32'(race_time), 32'd43);
      lap_finished = 1'b0;
      clk(1);
      chk("s3b_done_pulse", 32'(lap_done), 32'h0);

      // 4: third lap at lap_time 30 finishes the race
      clk(119);
      chk("s4_lap30", 32'(lap_time), 32'd30);
      lap_finished = 1'b1;
      clk(1);
      chk("s4_finished", 32'(race_finished), 32'h1);
      chk("s4_running", 32'(race_running), 32'h0);
      chk("s4_best", 32'(best_lap), 32'd18);
      chk("s4_last", 32'(last_lap), 32'd30);
      chk("s4_count", 32'(lap_count), 32'd3);
      chk("s4_done", 32'(lap_done), 32'h1);
      chk("s4_race", 32'(race_time), 32'd73);
      for (int i = 0; i < 100; i++) begin
         lap_finished = i[0];
         clk(1);
         chk("s4_frz_done", 32'(lap_done), 32'h0);
         chk("s4_frz_count", 32'(lap_count), 32'd3);
         chk("s4_frz_race", 32'(race_time), 32'd73);
         chk("s4_frz_lap", 32'(lap_time), 32'd0);
      end
      chk("s4_frz_finished", 32'(race_finished), 32'h1);
      chk("s4_frz_best", 32'(best_lap), 32'd18);

      // 5: race_start wins over a simultaneous valid lap
      lap_finished = 1'b0;
      race_start = 1'b1;
      clk(1);
      race_start = 1'b0;
      chk("s5_restart_running", 32'(race_running), 32'h1);
      chk("s5_restart_finished", 32'(race_finished), 32'h0);
      clk(10);
      chk("s5_lap2", 32'(lap_time), 32'd2);
      lap_finished = 1'b1;
      checkpoints_passed = 1'b1;
      race_start = 1'b1;
      clk(1);
      race_start = 1'b0;
      chk("s5_done", 32'(lap_done), 32'h0);
      chk("s5_count", 32'(lap_count), 32'd0);
      chk("s5_best", 32'(best_lap), 32'hFFFF);
      chk("s5_last", 32'(last_lap), 32'd0);
      chk("s5_lap", 32'(lap_time), 32'd0);
      chk("s5_race", 32'(race_time), 32'd0);

      // 6: asynchronous reset between edges, then a clean restart
      lap_finished = 1'b0;
      clk(20);
      chk("s6_lap5", 32'(lap_time), 32'd5);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_values("arst");
      rst = 1'b0;
      clk(1);
      chk("s6_idle_running", 32'(race_running), 32'h0);
      race_start = 1'b1;
      clk(1);
      race_start = 1'b0;
      chk("s6_run", 32'(race_running), 32'h1);
      clk(8);
      chk("s6_lap", 32'(lap_time), 32'd2);
      chk("s6_race", 32'(race_time), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lap_timer.md
# lap_timer

Race-timing stage downstream of the track checkpoint detector. It consumes the detector's `lap_finished` and `checkpoints_passed` flags and counts valid laps. It times the current lap, last lap, best lap and total race in centisecond ticks, and flags the end of the race after a fixed number of laps. Outputs feed the HUD/text overlay and game-state logic.

## Interface
Parameters:
- `TICK_DIV`, default 650000: pclk cycles per timing tick (65 MHz → 10 ms tick); legal range ≥ 2.
- `LAPS`, default 3: laps per race; legal range 1–15.

Ports:
- `pclk` in 1: system/pixel clock; all logic on rising edge.
- `rst` in 1: **reset is asynchronous and active-high, on a single clock `pclk`.**
- `race_start` in 1: one-cycle pulse; (re)starts a race.
- `lap_finished` in 1: level; high while the car is inside the finish zone.
- `checkpoints_passed` in 1: high when all checkpoints were collected. The upstream guarantees it is still high in the first cycle `lap_finished` is high.
- `lap_count` out 4: completed valid laps.
- `lap_time` out 16: ticks in the current lap.
- `last_lap` out 16: ticks of the most recent valid lap.
- `best_lap` out 16: minimum valid lap; 16'hFFFF = none yet.
- `race_time` out 20: ticks since race start.
- `lap_done` out 1: one-cycle pulse per valid lap.
- `race_running` out 1: high in RUNNING.
- `race_finished` out 1: high in FINISHED.

## Operation
- FSM states: IDLE, RUNNING, FINISHED. Reset state is IDLE.
- Reset values: all counters 0, `best_lap`=16'hFFFF, `lap_done`/`race_running`/`race_finished`=0, prescaler 0, `lf_d`=0.
- `race_start` in any state goes to RUNNING. It also clears `lap_count`, `lap_time`, `last_lap`, `race_time` and the prescaler, and sets `best_lap`=16'hFFFF.
- In RUNNING, the prescaler counts 0..TICK_DIV-1 and wraps. On the wrap cycle a tick occurs: `lap_time`+1 and `race_time`+1. Both saturate at all-ones and do not wrap.
- Edge detect: `lf_d` is `lap_finished` delayed one cycle. A valid lap is `lap_finished & ~lf_d & checkpoints_passed`, evaluated in RUNNING only.
- A rising edge of `lap_finished` without `checkpoints_passed` is ignored: no count and no timer change. This covers a short-cut, reversing over the line, or the very first crossing from the grid.
- On a valid lap:
  - `last_lap` ← current `lap_time`. A tick in the same cycle is not included.
  - `best_lap` ← min(`best_lap`, `lap_time`).
  - `lap_count`+1.
  - `lap_time` ← 0 and prescaler ← 0.
  - `lap_done`=1 for one cycle.
  - If the new count equals LAPS, go to FINISHED.
- In FINISHED, every counter and register is frozen. Only `race_start` or `rst` leaves this state.
- In IDLE, counters hold and `lap_finished` is ignored. `lf_d` still tracks the input in all states.
- Simultaneous events: `race_start` wins over a valid lap in the same cycle. That lap is discarded and `lap_done` stays 0.

## Timing
- Every output is registered. A valid-lap condition at cycle N gives updated `lap_count`/`last_lap`/`best_lap`, `lap_done`=1 and `lap_time`=0 at cycle N+1.
- `race_finished` rises at N+1 of the final lap. `race_running` falls in that same cycle.
- After `race_start` at cycle N: `race_running`=1 at N+1. The first tick lands at cycle N+TICK_DIV.
- A valid lap requires `lap_finished` to go low and high again. Holding it high counts at most one lap.
- An async `rst` mid-race drops every output to its reset value immediately, with no wait for a clock edge.

## Test plan
All scenarios use TICK_DIV=4 and LAPS=3.
1. Reset, then `race_start`, then 40 clocks → `race_running`=1, `lap_time`=10, `race_time`=10, `lap_count`=0, `best_lap`=FFFF.
2. `lap_finished` rising edge with `checkpoints_passed`=0 → no `lap_done`, `lap_count`=0, `lap_time` keeps counting.
3. Valid lap at `lap_time`=25, then a valid lap at `lap_time`=18 → `last_lap`=18, `best_lap`=18, `lap_count`=2, one `lap_done` pulse each. Holding `lap_finished` high for 10 cycles yields a single pulse.
4. Third valid lap at `lap_time`=30 → `race_finished`=1, `race_running`=0, `best_lap`=18. Further laps and ticks change nothing for 100 clocks.
5. `race_start` in the same cycle as a valid lap → `lap_done`=0, `lap_count`=0, `best_lap`=FFFF, timers 0.
6. Assert `rst` mid-race between clock edges → outputs reach reset values before the next `pclk` edge. After `race_start`, timing restarts from 0.
